alu_seq: RTL and testbench
==========================

# alu_seq

Registered, parametrised successor to the single-cycle ALU. It executes the 16 data-processing ALU operations with a one-cycle registered result and keeps an internal architectural NZCV flag register, so ADC/SBC/RSC draw carry from it directly. It also runs iterative MUL/MLA over several cycles behind a valid/ready handshake. It sits between the register-read/shifter stage and writeback in the multi-cycle core.

## Interface
- `WIDTH`, 32, datapath width (≥ 4).
- `MUL_STEP`, 1, multiplier bits retired per cycle; must divide `WIDTH`; legal values 1, 2, 4.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; a transfer happens on `in_valid & in_ready`.
- `src_a`, `src_b`  in  WIDTH  operands; `src_b` is the post-shifter operand.
- `src_c`  in  WIDTH  MLA accumulate addend.
- `alu_control`  in  4  op code, same encoding as the existing ALU (0000 AND … 1111 MVN).
- `mul_op`  in  2  00 ALU op, 01 MUL, 10 MLA, 11 treated as MUL.
- `set_flags`  in  1  S bit; update NZCV on completion.
- `shifter_carry_in`  in  1  shifter carry-out, used as C by logical ops.
- `out_valid`  out  1  single-cycle pulse when `result` is valid.
- `result`  out  WIDTH  registered result.
- `result_we`  out  1  result is to be written back; 0 for TST/TEQ/CMP/CMN; qualified by `out_valid`.
- `flags`  out  4  architectural {N,Z,C,V}.
- `busy`  out  1  a multiply is in progress.

## Operation
- Arithmetic uses the (WIDTH+1)-bit form `a + b' + cin`. C is bit WIDTH of that sum. V = (a[MSB]==b'[MSB]) & (sum[MSB]!=a[MSB]).
  - ADD/CMN: a + b + 0.
  - ADC: a + b + C.
  - SUB/CMP: a + ~b + 1.
  - SBC: a + ~b + C.
  - RSB: b + ~a + 1.
  - RSC: b + ~a + C.
- Subtract C therefore means "no borrow", per ARM.
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN):
  - C ← `shifter_carry_in`.
  - V unchanged.
- N ← result[MSB]. Z ← (result == 0).
- Flag write occurs only when `set_flags` is 1. TST/TEQ/CMP/CMN always update flags, regardless of `set_flags`.
- MUL: low WIDTH bits of a×b. MLA: low WIDTH bits of a×b + c.
  - When `set_flags` is set, N and Z update; C and V are unchanged.
  - `result_we` = 1.
- FSM has two states:
  - IDLE: `in_ready` = 1. An accepted ALU op stays in IDLE. An accepted multiply moves to MUL_RUN.
  - MUL_RUN: `in_ready` = 0, `busy` = 1. A counter counts down from WIDTH/MUL_STEP − 1. When it reaches 0, the block returns to IDLE and registers the result.
- Operands (a, b, c, control, set_flags) are captured at accept. Inputs are ignored during MUL_RUN.
- `in_valid` while `in_ready` = 0 is not consumed; the requester must hold it.

## Timing
- ALU op accepted at edge t:
  - `result`, `result_we` and `flags` update at edge t.
  - `out_valid` is high for the cycle following edge t.
  - Throughput is one op per cycle.
- Back-to-back ops: an op accepted at edge t+1 sees flags written at edge t. An ADC immediately after an ADDS uses the new C.
- Multiply accepted at edge t:
  - Iterations occur at edges t+1 … t+N, where N = WIDTH/MUL_STEP.
  - `result`/`flags` update at edge t+N, and `out_valid` is high the following cycle.
  - `in_ready` is high again in that same cycle, so a new op may be accepted on edge t+N+1.
- `out_valid` has no backpressure and lasts exactly one cycle.
- Reset values:
  - `result` = 0, `result_we` = 0, `out_valid` = 0, `flags` = 0000, `busy` = 0, FSM = IDLE.
  - `in_ready` = 0 while `reset` is high, and 1 in the first cycle after.
- Reset mid-multiply aborts the operation. No `out_valid` is produced and flags are cleared.
- No-accept cycles leave `result`, `flags` and `result_we` holding their values; `out_valid` = 0.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` enum (16 codes).
  - `mul_op_e` enum.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module `mul_iter`:
  - Parameters WIDTH and MUL_STEP.
  - Iterative shift-add multiplier with start/done, an accumulator preloaded with c for MLA, and a step counter.
- The parent owns the FSM, the combinational ALU, the flag register and the output registers.

## Test plan
- ADDS 0x7FFFFFFF + 0x00000001 → `result` 0x80000000, flags N1 Z0 C0 V1, `result_we` 1, `out_valid` one cycle after accept.
- SUBS 5 − 5, then next-cycle SBC 5 − 3 → first gives 0 with flags Z1 C1; SBC (C=1) gives 2.
- CMP 3, 7, then ADC 1 + 1 → CMP gives `result_we` 0, flags N1 Z0 C0 V0; ADC gives 2.
- MLA 0x0000FFFF × 0x0000FFFF + 0x10, with set_flags and prior C=1, V=1 → `in_ready` low 32 cycles (MUL_STEP=1), `result` 0xFFFE0011, N1 Z0, C and V still 1.
- Reset asserted at iteration 10 of a MUL → no `out_valid`, flags 0000, `in_ready` 1 the cycle after reset drops, and the next ADD completes normally.
- WIDTH=8, MUL_STEP=4 instance:
  - ADDS 0xFF + 0x01 → 0x00, flags Z1 C1.
  - MUL 0x0F × 0x11 → 0xFF after 2 iteration cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU and its iterative multiplier.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_EOR = 4'b0001,
        ALU_SUB = 4'b0010,
        ALU_RSB = 4'b0011,
        ALU_ADD = 4'b0100,
        ALU_ADC = 4'b0101,
        ALU_SBC = 4'b0110,
        ALU_RSC = 4'b0111,
        ALU_TST = 4'b1000,
        ALU_TEQ = 4'b1001,
        ALU_CMP = 4'b1010,
        ALU_CMN = 4'b1011,
        ALU_ORR = 4'b1100,
        ALU_MOV = 4'b1101,
        ALU_BIC = 4'b1110,
        ALU_MVN = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        MUL_NONE = 2'b00,
        MUL_MUL  = 2'b01,
        MUL_MLA  = 2'b10,
        MUL_ALT  = 2'b11
    } mul_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Compare/test ops write flags unconditionally and never write back a result.
    function automatic logic is_compare(input alu_op_e op);
        return (op == ALU_TST) || (op == ALU_TEQ) || (op == ALU_CMP) || (op == ALU_CMN);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-read stage and the sequential ALU.
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_c;
    logic [3:0]       alu_control;
    logic [1:0]       mul_op;
    logic             set_flags;
    logic             shifter_carry_in;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             result_we;
    logic [3:0]       flags;
    logic             busy;

    modport master (
        output in_valid, src_a, src_b, src_c, alu_control, mul_op, set_flags, shifter_carry_in,
        input  in_ready, out_valid, result, result_we, flags, busy
    );

    modport slave (
        input  in_valid, src_a, src_b, src_c, alu_control, mul_op, set_flags, shifter_carry_in,
        output in_ready, out_valid, result, result_we, flags, busy
    );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
module mul_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             acc_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int N     = WIDTH / MUL_STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic             running_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] pp [MUL_STEP];

    generate
        for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
        end
    endgenerate

    // product is the accumulator after this cycle's step; the parent registers it on done.
    always_comb begin
        product = acc_reg;
        for (int i = 0; i < MUL_STEP; i++) begin
            product = product + pp[i];
        end
    end

    assign done = running_reg && (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            running_reg <= 1'b0;
            cnt_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
        end else if (start) begin
            running_reg <= 1'b1;
            cnt_reg     <= CNT_W'(N - 1);
            mcand_reg   <= a;
            mplier_reg  <= b;
            acc_reg     <= acc_en ? c : '0;
        end else if (running_reg) begin
            acc_reg    <= product;
            mcand_reg  <= mcand_reg << MUL_STEP;
            mplier_reg <= mplier_reg >> MUL_STEP;
            cnt_reg    <= cnt_reg - CNT_W'(1);
            if (cnt_reg == '0) begin
                running_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with architectural NZCV flags and an iterative MUL/MLA path.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);
    typedef enum logic {ST_IDLE, ST_MUL_RUN} state_e;

    state_e           state_reg;
    logic [WIDTH-1:0] result_reg;
    logic             result_we_reg;
    logic             out_valid_reg;
    logic [3:0]       flags_reg;
    logic             mul_sf_reg;

    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    alu_op_e          op;
    logic [WIDTH-1:0] arith_a;
    logic [WIDTH-1:0] arith_b;
    logic             cin;
    logic             is_arith;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    logic             alu_flag_we;
    logic             alu_we;

    assign accept = bus.in_valid && bus.in_ready;
    assign is_mul = mul_op_e'(bus.mul_op) != MUL_NONE;

    mul_iter #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .acc_en  (mul_op_e'(bus.mul_op) == MUL_MLA),
        .a       (bus.src_a),
        .b       (bus.src_b),
        .c       (bus.src_c),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        op        = alu_op_e'(bus.alu_control);
        arith_a   = bus.src_a;
        arith_b   = bus.src_b;
        cin       = 1'b0;
        is_arith  = 1'b1;
        logic_res = '0;
        case (op)
            ALU_ADD, ALU_CMN: cin = 1'b0;
            ALU_ADC:          cin = flags_reg[FLAG_C];
            ALU_SUB, ALU_CMP: begin arith_b = ~bus.src_b; cin = 1'b1; end
            ALU_SBC:          begin arith_b = ~bus.src_b; cin = flags_reg[FLAG_C]; end
            ALU_RSB:          begin arith_a = bus.src_b; arith_b = ~bus.src_a; cin = 1'b1; end
            ALU_RSC:          begin arith_a = bus.src_b; arith_b = ~bus.src_a; cin = flags_reg[FLAG_C]; end
            default:          is_arith = 1'b0;
        endcase
        case (op)
            ALU_AND, ALU_TST: logic_res = bus.src_a & bus.src_b;
            ALU_EOR, ALU_TEQ: logic_res = bus.src_a ^ bus.src_b;
            ALU_ORR:          logic_res = bus.src_a | bus.src_b;
            ALU_MOV:          logic_res = bus.src_b;
            ALU_BIC:          logic_res = bus.src_a & ~bus.src_b;
            ALU_MVN:          logic_res = ~bus.src_b;
            default:          logic_res = '0;
        endcase
        sum        = {1'b0, arith_a} + {1'b0, arith_b} + {{WIDTH{1'b0}}, cin};
        alu_result = is_arith ? sum[WIDTH-1:0] : logic_res;
        alu_flags[FLAG_N] = alu_result[WIDTH-1];
        alu_flags[FLAG_Z] = (alu_result == '0);
        // Logical ops take C from the shifter and leave V alone.
        alu_flags[FLAG_C] = is_arith ? sum[WIDTH] : bus.shifter_carry_in;
        alu_flags[FLAG_V] = is_arith ? ((arith_a[WIDTH-1] == arith_b[WIDTH-1]) &&
                                        (sum[WIDTH-1] != arith_a[WIDTH-1]))
                                     : flags_reg[FLAG_V];
        alu_flag_we = bus.set_flags || is_compare(op);
        alu_we      = !is_compare(op);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            result_reg    <= '0;
            result_we_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            flags_reg     <= '0;
            mul_sf_reg    <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept && is_mul) begin
                        state_reg  <= ST_MUL_RUN;
                        mul_sf_reg <= bus.set_flags;
                    end else if (accept) begin
                        result_reg    <= alu_result;
                        result_we_reg <= alu_we;
                        out_valid_reg <= 1'b1;
                        if (alu_flag_we) begin
                            flags_reg <= alu_flags;
                        end
                    end
                end
                ST_MUL_RUN: begin
                    if (mul_done) begin
                        state_reg     <= ST_IDLE;
                        result_reg    <= mul_product;
                        result_we_reg <= 1'b1;
                        out_valid_reg <= 1'b1;
                        if (mul_sf_reg) begin
                            flags_reg[FLAG_N] <= mul_product[WIDTH-1];
                            flags_reg[FLAG_Z] <= (mul_product == '0);
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == ST_IDLE) && !reset;
    assign bus.busy      = (state_reg == ST_MUL_RUN);
    assign bus.result    = result_reg;
    assign bus.result_we = result_we_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.flags     = flags_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit/step-1 instance and an 8-bit/step-4 instance.
module tb_alu_seq;
    localparam logic [3:0] OP_AND = 4'b0000, OP_SUB = 4'b0010, OP_RSB = 4'b0011,
                           OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110,
                           OP_TEQ = 4'b1001, OP_CMP = 4'b1010, OP_MVN = 4'b1111;
    localparam logic [1:0] M_ALU = 2'b00, M_MUL = 2'b01, M_MLA = 2'b10;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) b32();
    alu_seq_if #(.WIDTH(8))  b8();

    alu_seq #(.WIDTH(32), .MUL_STEP(1)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
    alu_seq #(.WIDTH(8),  .MUL_STEP(4)) dut8  (.clk(clk), .reset(reset), .bus(b8.slave));

    task automatic drive32(input logic [3:0] op, input logic [1:0] mop, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c, input logic sf, input logic sc);
        b32.alu_control = op; b32.mul_op = mop; b32.src_a = a; b32.src_b = b; b32.src_c = c;
        b32.set_flags = sf; b32.shifter_carry_in = sc; b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        $display("[TB] w32 op=%b mul=%b a=%h b=%h c=%h s=%0b sc=%0b -> out_valid=%0b result=%h we=%0b flags=%b",
                 op, mop, a, b, c, sf, sc, b32.out_valid, b32.result, b32.result_we, b32.flags);
    endtask

    task automatic drive8(input logic [3:0] op, input logic [1:0] mop, input logic [7:0] a,
                          input logic [7:0] b, input logic sf);
        b8.alu_control = op; b8.mul_op = mop; b8.src_a = a; b8.src_b = b; b8.src_c = 8'h00;
        b8.set_flags = sf; b8.shifter_carry_in = 1'b0; b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        $display("[TB] w8 op=%b mul=%b a=%h b=%h s=%0b -> out_valid=%0b result=%h we=%0b flags=%b",
                 op, mop, a, b, sf, b8.out_valid, b8.result, b8.result_we, b8.flags);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (b32.in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", b32.in_ready); end
        tests_run++;
        if ({b32.result, b32.result_we, b32.out_valid, b32.flags, b32.busy} !== 39'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: result=%h we=%b ov=%b flags=%b busy=%b want all zero",
                     b32.result, b32.result_we, b32.out_valid, b32.flags, b32.busy);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (b32.in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_in_ready: got %b want 1", b32.in_ready); end
    endtask

    task automatic test_adds_overflow;
        drive32(OP_ADD, M_ALU, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 1'b1, 1'b0);
        tests_run++;
        if (b32.result !== 32'h8000_0000) begin tests_failed++; $display("FAIL adds_result: got %h want 80000000", b32.result); end
        tests_run++;
        if (b32.flags !== 4'b1001) begin tests_failed++; $display("FAIL adds_flags: got %b want 1001", b32.flags); end
        tests_run++;
        if ({b32.out_valid, b32.result_we} !== 2'b11) begin tests_failed++; $display("FAIL adds_valid_we: got %b want 11", {b32.out_valid, b32.result_we}); end
        @(posedge clk); #1;
        tests_run++;
        if (b32.out_valid !== 1'b0) begin tests_failed++; $display("FAIL adds_pulse_width: got %b want 0", b32.out_valid); end
        tests_run++;
        if (b32.result !== 32'h8000_0000) begin tests_failed++; $display("FAIL idle_hold: got %h want 80000000", b32.result); end
    endtask

    task automatic test_back_to_back;
        drive32(OP_SUB, M_ALU, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
        tests_run++;
        if ({b32.result, b32.flags} !== {32'd0, 4'b0110}) begin
            tests_failed++; $display("FAIL subs_zero: got %h/%b want 00000000/0110", b32.result, b32.flags);
        end
        drive32(OP_SBC, M_ALU, 32'd5, 32'd3, 32'h0, 1'b0, 1'b0);
        tests_run++;
        if ({b32.out_valid, b32.result} !== {1'b1, 32'd2}) begin
            tests_failed++; $display("FAIL sbc_b2b: got ov=%b %h want ov=1 00000002", b32.out_valid, b32.result);
        end
        tests_run++;
        if (b32.flags !== 4'b0110) begin tests_failed++; $display("FAIL sbc_flags_kept: got %b want 0110", b32.flags); end
    endtask

    task automatic test_compare;
        drive32(OP_CMP, M_ALU, 32'd3, 32'd7, 32'h0, 1'b0, 1'b0);
        tests_run++;
        if ({b32.result_we, b32.flags} !== {1'b0, 4'b1000}) begin
            tests_failed++; $display("FAIL cmp: got we=%b flags=%b want we=0 flags=1000", b32.result_we, b32.flags);
        end
        drive32(OP_ADC, M_ALU, 32'd1, 32'd1, 32'h0, 1'b0, 1'b0);
        tests_run++;
        if ({b32.result_we, b32.result} !== {1'b1, 32'd2}) begin
            tests_failed++; $display("FAIL adc_c0: got we=%b %h want we=1 00000002", b32.result_we, b32.result);
        end
    endtask

    task automatic test_logical;
        drive32(OP_ADD, M_ALU, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        tests_run++;
        if (b32.flags !== 4'b0111) begin tests_failed++; $display("FAIL adds_cv: got %b want 0111", b32.flags); end
        drive32(OP_AND, M_ALU, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 1'b1, 1'b0);
        tests_run++;
        if ({b32.result, b32.flags} !== {32'h00F0_00F0, 4'b0001}) begin
            tests_failed++; $display("FAIL ands: got %h/%b want 00f000f0/0001", b32.result, b32.flags);
        end
        drive32(OP_MVN, M_ALU, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        tests_run++;
        if ({b32.result, b32.flags} !== {32'hFFFF_FFFF, 4'b1011}) begin
            tests_failed++; $display("FAIL mvns: got %h/%b want ffffffff/1011", b32.result, b32.flags);
        end
        drive32(OP_RSB, M_ALU, 32'd3, 32'd10, 32'h0, 1'b1, 1'b0);
        tests_run++;
        if ({b32.result, b32.flags} !== {32'd7, 4'b0010}) begin
            tests_failed++; $display("FAIL rsbs: got %h/%b want 00000007/0010", b32.result, b32.flags);
        end
        drive32(OP_TEQ, M_ALU, 32'd5, 32'd5, 32'h0, 1'b0, 1'b0);
        tests_run++;
        if ({b32.result_we, b32.flags} !== {1'b0, 4'b0100}) begin
            tests_failed++; $display("FAIL teq: got we=%b flags=%b want we=0 flags=0100", b32.result_we, b32.flags);
        end
    endtask

    task automatic test_mla;
        int cycles;
        drive32(OP_ADD, M_ALU, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        drive32(OP_ADD, M_MLA, 32'h0000_FFFF, 32'h0000_FFFF, 32'h10, 1'b1, 1'b0);
        tests_run++;
        if ({b32.in_ready, b32.busy, b32.out_valid} !== 3'b010) begin
            tests_failed++; $display("FAIL mla_start: got rdy/busy/ov=%b want 010", {b32.in_ready, b32.busy, b32.out_valid});
        end
        cycles = 0;
        while (b32.in_ready !== 1'b1 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        tests_run++;
        if (cycles !== 32) begin tests_failed++; $display("FAIL mla_latency: got %0d cycles want 32", cycles); end
        tests_run++;
        if ({b32.out_valid, b32.result_we, b32.result} !== {2'b11, 32'hFFFE_0011}) begin
            tests_failed++; $display("FAIL mla_result: got ov=%b we=%b %h want 1 1 fffe0011", b32.out_valid, b32.result_we, b32.result);
        end
        tests_run++;
        if ({b32.flags, b32.busy} !== {4'b1011, 1'b0}) begin
            tests_failed++; $display("FAIL mla_flags: got %b busy=%b want 1011 busy=0", b32.flags, b32.busy);
        end
        drive32(OP_ADD, M_ALU, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0);
        tests_run++;
        if ({b32.out_valid, b32.result, b32.flags} !== {1'b1, 32'd3, 4'b1011}) begin
            tests_failed++; $display("FAIL add_after_mla: got ov=%b %h/%b want 1 00000003/1011", b32.out_valid, b32.result, b32.flags);
        end
    endtask

    task automatic test_reset_mid_mul;
        int spurious;
        drive32(OP_ADD, M_MUL, 32'h0000_1234, 32'h0000_0010, 32'h0, 1'b1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({b32.in_ready, b32.busy, b32.out_valid, b32.flags} !== 7'd0) begin
            tests_failed++; $display("FAIL mid_reset: got rdy/busy/ov=%b flags=%b want 000 0000",
                                     {b32.in_ready, b32.busy, b32.out_valid}, b32.flags);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (b32.in_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_ready: got %b want 1", b32.in_ready); end
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (b32.out_valid === 1'b1) spurious++;
        end
        tests_run++;
        if (spurious !== 0) begin tests_failed++; $display("FAIL aborted_mul_valid: got %0d pulses want 0", spurious); end
        drive32(OP_ADD, M_ALU, 32'd2, 32'd3, 32'h0, 1'b0, 1'b0);
        tests_run++;
        if ({b32.out_valid, b32.result, b32.flags} !== {1'b1, 32'd5, 4'b0000}) begin
            tests_failed++; $display("FAIL add_after_reset: got ov=%b %h/%b want 1 00000005/0000", b32.out_valid, b32.result, b32.flags);
        end
    endtask

    task automatic test_width8;
        int cycles;
        drive8(OP_ADD, M_ALU, 8'hFF, 8'h01, 1'b1);
        tests_run++;
        if ({b8.result, b8.flags} !== {8'h00, 4'b0110}) begin
            tests_failed++; $display("FAIL w8_adds: got %h/%b want 00/0110", b8.result, b8.flags);
        end
        drive8(OP_ADD, M_MUL, 8'h0F, 8'h11, 1'b0);
        cycles = 0;
        while (b8.in_ready !== 1'b1 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        tests_run++;
        if (cycles !== 2) begin tests_failed++; $display("FAIL w8_mul_latency: got %0d cycles want 2", cycles); end
        tests_run++;
        if ({b8.out_valid, b8.result_we, b8.result, b8.flags} !== {2'b11, 8'hFF, 4'b0110}) begin
            tests_failed++; $display("FAIL w8_mul: got ov=%b we=%b %h/%b want 1 1 ff/0110",
                                     b8.out_valid, b8.result_we, b8.result, b8.flags);
        end
    endtask

    initial begin
        reset = 1'b1;
        b32.in_valid = 1'b0; b32.src_a = '0; b32.src_b = '0; b32.src_c = '0; b32.alu_control = '0;
        b32.mul_op = '0; b32.set_flags = 1'b0; b32.shifter_carry_in = 1'b0;
        b8.in_valid = 1'b0; b8.src_a = '0; b8.src_b = '0; b8.src_c = '0; b8.alu_control = '0;
        b8.mul_op = '0; b8.set_flags = 1'b0; b8.shifter_carry_in = 1'b0;
        test_reset;
        test_adds_overflow;
        test_back_to_back;
        test_compare;
        test_logical;
        test_mla;
        test_reset_mid_mul;
        test_width8;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
